// File: rtl/fifo2axi4_wr.sv
// fifo2axi4_wr: drains a first-word-fall-through pixel FIFO into DDR frame
// buffers using fixed-length AXI4 INCR write bursts. A burst is launched only
// when the FIFO already holds a full burst, so the W phase never starves
// unless the FIFO is read elsewhere. The frame buffer is chosen from the
// capture stage's frame index at the first burst of each frame.
module fifo2axi4_wr #(
    parameter int                   FAW             = 8,
    parameter int                   AXI4_DATA_WIDTH = 128,
    parameter int                   AXI_ADDR_WIDTH  = 32,
    parameter int                   BURST_LEN       = 16,
    parameter int                   FRAME_BEATS     = 518400,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE   = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0080_0000,
    parameter int                   FIDX_W          = 2
) (
    input  logic                         M_AXI_ACLK,
    input  logic                         M_AXI_ARESETN,
    input  logic                         wr_en,
    input  logic [FIDX_W-1:0]            frame_idx,
    input  logic [AXI4_DATA_WIDTH-1:0]   frd_dat,
    input  logic                         frd_empty,
    input  logic [FAW:0]                 frd_cnt,
    output logic                         frd_en,
    output logic [AXI_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
    output logic [7:0]                   M_AXI_AWLEN,
    output logic [2:0]                   M_AXI_AWSIZE,
    output logic [1:0]                   M_AXI_AWBURST,
    output logic                         M_AXI_AWVALID,
    input  logic                         M_AXI_AWREADY,
    output logic [AXI4_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI4_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                         M_AXI_WLAST,
    output logic                         M_AXI_WVALID,
    input  logic                         M_AXI_WREADY,
    input  logic [1:0]                   M_AXI_BRESP,
    input  logic                         M_AXI_BVALID,
    output logic                         M_AXI_BREADY,
    output logic                         frame_done,
    output logic                         bresp_err
);

    localparam int STRB_W = AXI4_DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(STRB_W);
    localparam int BOFF_W = $clog2(FRAME_BEATS + 1);
    localparam int CNT_W  = FAW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic                      awvalid_q;
    logic                      bready_q;
    logic                      frame_done_q;
    logic                      bresp_err_q;
    logic [7:0]                beat_q;
    logic [BOFF_W-1:0]         beat_off_q;
    logic [AXI_ADDR_WIDTH-1:0] frame_base_q;

    logic                      start_s;
    logic [AXI_ADDR_WIDTH-1:0] base_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_d;
    logic                      wvalid_s;
    logic                      wlast_s;
    logic                      w_hs_s;
    logic                      b_hs_s;
    logic [BOFF_W-1:0]         beat_off_d;
    logic                      wrap_s;

    // Start condition, frame base selection and burst address for the next AW.
    always_comb begin
        start_s  = 1'b0;
        base_d   = frame_base_q;
        awaddr_d = '0;
        if ((state_q == ST_IDLE) && wr_en && (frd_cnt >= CNT_W'(BURST_LEN))) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        // A new frame re-selects its buffer; mid-frame the latched base stays.
        if (beat_off_q == '0) begin
            base_d = FRAME_BASE + (AXI_ADDR_WIDTH'(frame_idx) * FRAME_STRIDE);
        end else begin
            base_d = frame_base_q;
        end
        awaddr_d = base_d + (AXI_ADDR_WIDTH'(beat_off_q) << BSHIFT);
    end

    // W-channel qualifiers and frame offset advance after each burst.
    always_comb begin
        wvalid_s   = 1'b0;
        wlast_s    = 1'b0;
        beat_off_d = beat_off_q + BOFF_W'(BURST_LEN);
        wrap_s     = 1'b0;
        if (state_q == ST_W) begin
            wvalid_s = ~frd_empty;
            wlast_s  = (beat_q == 8'(BURST_LEN - 1));
        end else begin
            wvalid_s = 1'b0;
            wlast_s  = 1'b0;
        end
        if (beat_off_d == BOFF_W'(FRAME_BEATS)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    assign w_hs_s = wvalid_s & M_AXI_WREADY;
    assign b_hs_s = bready_q & M_AXI_BVALID;

    // Burst FSM: AW request, W beats, B response, plus frame bookkeeping.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            frame_done_q <= 1'b0;
            bresp_err_q  <= 1'b0;
            beat_q       <= 8'd0;
            beat_off_q   <= '0;
            frame_base_q <= FRAME_BASE;
        end else begin
            frame_done_q <= 1'b0;
            // Error is sticky and does not disturb the burst sequence.
            if (b_hs_s && (M_AXI_BRESP != 2'b00)) begin
                bresp_err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        frame_base_q <= base_d;
                        awaddr_q     <= awaddr_d;
                        awvalid_q    <= 1'b1;
                        state_q      <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= 8'd0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        beat_q <= beat_q + 8'd1;
                        if (wlast_s) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (M_AXI_BVALID) begin
                        bready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (wrap_s) begin
                            beat_off_q   <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            beat_off_q   <= beat_off_d;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    awvalid_q <= 1'b0;
                    bready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frd_en        = w_hs_s;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'(BSHIFT);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = frd_dat;
    assign M_AXI_WSTRB   = {STRB_W{1'b1}};
    assign M_AXI_WLAST   = wlast_s;
    assign M_AXI_WVALID  = wvalid_s;
    assign M_AXI_BREADY  = bready_q;
    assign frame_done    = frame_done_q;
    assign bresp_err     = bresp_err_q;

endmodule

// File: tb/tb_fifo2axi4_wr.sv
// Directed bench for fifo2axi4_wr with a 4-beat burst, 8-beat frame setup.
module tb_fifo2axi4_wr;

    localparam int FAW = 4;
    localparam int DW  = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [1:0]    frame_idx;
    logic [DW-1:0] frd_dat;
    logic          frd_empty;
    logic [FAW:0]  frd_cnt;
    logic          frd_en;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [15:0]   wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;
    logic          frame_done;
    logic          bresp_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fifo2axi4_wr #(
        .FAW(FAW), .AXI4_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(32), .BURST_LEN(4),
        .FRAME_BEATS(8), .FRAME_BASE(32'h1000_0000), .FRAME_STRIDE(32'h0080_0000),
        .FIDX_W(2)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .wr_en(wr_en), .frame_idx(frame_idx),
        .frd_dat(frd_dat), .frd_empty(frd_empty), .frd_cnt(frd_cnt), .frd_en(frd_en),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .frame_done(frame_done),
        .bresp_err(bresp_err)
    );

    function automatic logic [DW-1:0] wordval(input int k);
        return {32'hD00D_0000 + 32'(k), 32'(k), ~32'(k), 32'hCAFE_0000 ^ 32'(k)};
    endfunction

    // FIFO model: written by the stimulus, popped by the monitor on frd_en.
    logic [DW-1:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    always_comb begin
        frd_dat   = mem[rp[7:0]];
        frd_empty = (wp == rp);
        frd_cnt   = 5'(wp - rp);
    end

    // Slave model: always-ready or random stalls.
    logic       rnd_mode = 1'b0;
    logic [1:0] bresp_sel = 2'b00;
    always @(negedge clk) begin
        if (rnd_mode) begin
            awready = ($urandom_range(0, 3) != 0);
            wready  = ($urandom_range(0, 2) != 0);
            bvalid  = bready & ($urandom_range(0, 2) == 0);
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
            bvalid  = bready;
        end
        bresp = bresp_sel;
    end

    // Monitor: logs handshakes, scoreboards W data, checks stall stability.
    int aw_cnt = 0, b_cnt = 0, hs_cnt = 0, pop_cnt = 0, fd_cnt = 0;
    int data_bad = 0, aw_bad = 0, w_bad = 0;
    logic [31:0]   aw_log [0:63];
    logic          last_log [0:255];
    logic          aw_stall = 1'b0, w_stall = 1'b0;
    logic [31:0]   aw_prev = 32'd0;
    logic [DW-1:0] w_prev = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            aw_stall <= 1'b0;
            w_stall  <= 1'b0;
        end else begin
            if (aw_stall && (!awvalid || (awaddr != aw_prev))) aw_bad <= aw_bad + 1;
            aw_stall <= awvalid && !awready;
            aw_prev  <= awaddr;
            if (w_stall && (!wvalid || (wdata != w_prev))) w_bad <= w_bad + 1;
            w_stall <= wvalid && !wready;
            w_prev  <= wdata;
            if (awvalid && awready) begin
                aw_log[aw_cnt] <= awaddr;
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                if (wdata !== wordval(hs_cnt)) data_bad <= data_bad + 1;
                last_log[hs_cnt] <= wlast;
                hs_cnt <= hs_cnt + 1;
            end
            if (frd_en) begin
                pop_cnt <= pop_cnt + 1;
                rp      <= rp + 1;
            end
            if (bvalid && bready) b_cnt <= b_cnt + 1;
            if (frame_done) fd_cnt <= fd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = wordval(wp);
            wp++;
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return aw_cnt;
            1:       return b_cnt;
            default: return hs_cnt;
        endcase
    endfunction

    // which: 0 = AW handshakes, 1 = B handshakes, 2 = W handshakes
    task automatic wait_for(input int which, input int target, input string tag);
        int c;
        c = 0;
        while ((cnt_of(which) < target) && (c < 500)) begin
            @(posedge clk); #1;
            c++;
        end
        chk(tag, 128'(cnt_of(which) >= target), 128'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        frame_idx = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", awvalid, 128'd0);
        chk("rst_wvalid", wvalid, 128'd0);
        chk("rst_wlast", wlast, 128'd0);
        chk("rst_bready", bready, 128'd0);
        chk("rst_frd_en", frd_en, 128'd0);
        chk("rst_awaddr", awaddr, 128'd0);
        chk("rst_frame_done", frame_done, 128'd0);
        chk("rst_bresp_err", bresp_err, 128'd0);
        chk("const_awlen", awlen, 128'd3);
        chk("const_awsize", awsize, 128'd4);
        chk("const_awburst", awburst, 128'd1);
        chk("const_wstrb", wstrb, 128'hFFFF);

        // Three words are not enough to start a burst.
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1;
        push(3);
        repeat (5) @(posedge clk);
        #1;
        chk("fill3_awvalid", awvalid, 128'd0);
        @(negedge clk);
        push(1);
        @(posedge clk); #1;
        chk("fill4_awvalid", awvalid, 128'd1);
        chk("fill4_awaddr", awaddr, 128'h1000_0000);
        chk("fill4_awlen", awlen, 128'd3);
        wait_for(1, 1, "wait_b1");
        @(negedge clk);
        push(4);
        wait_for(1, 2, "wait_b2");
        repeat (2) @(posedge clk);
        #1;
        chk("f0_aw0", aw_log[0], 128'h1000_0000);
        chk("f0_aw1", aw_log[1], 128'h1000_0040);
        chk("f0_frame_done", fd_cnt, 128'd1);

        // Back-to-back bursts on frame 1; index change mid-frame is ignored.
        @(negedge clk);
        frame_idx = 2'd1;
        push(8);
        wait_for(0, 3, "wait_aw3");
        @(negedge clk);
        frame_idx = 2'd2;
        wait_for(1, 4, "wait_b4");
        repeat (2) @(posedge clk);
        #1;
        chk("f1_aw0", aw_log[2], 128'h1080_0000);
        chk("f1_aw1_midframe", aw_log[3], 128'h1080_0040);
        chk("f1_frame_done", fd_cnt, 128'd2);
        for (int i = 8; i < 16; i++) begin
            chk($sformatf("f1_wlast_%0d", i), last_log[i], 128'((i % 4) == 3));
        end
        chk("f1_data", data_bad, 128'd0);

        // Next frame picks up the new index.
        @(negedge clk);
        push(8);
        wait_for(1, 6, "wait_b6");
        repeat (2) @(posedge clk);
        #1;
        chk("f2_aw0", aw_log[4], 128'h1100_0000);
        chk("f2_aw1", aw_log[5], 128'h1100_0040);
        chk("f2_frame_done", fd_cnt, 128'd3);

        // Random slave stalls on frame 3.
        @(negedge clk);
        rnd_mode  = 1'b1;
        frame_idx = 2'd3;
        push(4);
        wait_for(1, 7, "wait_b7");
        @(negedge clk);
        push(4);
        wait_for(1, 8, "wait_b8");
        @(negedge clk);
        rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rnd_aw0", aw_log[6], 128'h1180_0000);
        chk("rnd_aw1", aw_log[7], 128'h1180_0040);
        chk("rnd_aw_stable", aw_bad, 128'd0);
        chk("rnd_w_stable", w_bad, 128'd0);
        chk("rnd_pop_eq_hs", pop_cnt, 128'(hs_cnt));
        chk("rnd_data", data_bad, 128'd0);
        chk("rnd_frame_done", fd_cnt, 128'd4);

        // Error response is sticky and bursts keep going.
        @(negedge clk);
        frame_idx = 2'd0;
        bresp_sel = 2'b10;
        push(4);
        wait_for(1, 9, "wait_b9");
        @(negedge clk);
        bresp_sel = 2'b00;
        chk("err_set", bresp_err, 128'd1);
        push(4);
        wait_for(1, 10, "wait_b10");
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", bresp_err, 128'd1);
        chk("err_aw0", aw_log[8], 128'h1000_0000);
        chk("err_aw1", aw_log[9], 128'h1000_0040);
        chk("err_frame_done", fd_cnt, 128'd5);

        // Reset during the second W beat abandons the burst.
        @(negedge clk);
        frame_idx = 2'd1;
        push(4);
        wait_for(2, 41, "wait_hs41");
        chk("rb_wvalid_pre", wvalid, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_awvalid", awvalid, 128'd0);
        chk("rb_wvalid", wvalid, 128'd0);
        chk("rb_bready", bready, 128'd0);
        chk("rb_frd_en", frd_en, 128'd0);
        chk("rb_bresp_err", bresp_err, 128'd0);
        chk("rb_aw", aw_log[10], 128'h1080_0000);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        frame_idx = 2'd0;
        @(negedge clk);
        push(1);
        @(posedge clk); #1;
        chk("ra_awvalid", awvalid, 128'd1);
        chk("ra_awaddr", awaddr, 128'h1000_0000);
        wait_for(1, 11, "wait_b11");
        repeat (2) @(posedge clk);
        #1;
        chk("ra_pop_eq_hs", pop_cnt, 128'(hs_cnt));
        chk("ra_hs_total", hs_cnt, 128'd45);
        chk("ra_data", data_bad, 128'd0);
        chk("ra_frame_done", fd_cnt, 128'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
